decode_operand_stage: RTL

- Parametrised successor of the decode pipeline stage.
- Resolves NUM_READ source operands against the register file, its own output register and FWD_DEPTH downstream stages.
- Generates a data-hazard stall, inserts bubbles, honours downstream stall and flush, and registers the result for execute.
- Sits between fetch and execute; jump evaluation and control decode stay outside.

---
 rtl/decode_operand_stage_pkg.sv | 14 +
 rtl/operand_forward_mux.sv | 35 +++
 rtl/decode_operand_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/decode_operand_stage_pkg.sv
// Shared types and constants for the decode operand stage and its forwarding mux.
package decode_operand_stage_pkg;

    typedef logic [4:0] reg_id_t;

    localparam reg_id_t ZERO_REG = '0;

    typedef struct packed {
        reg_id_t     registerId;
        logic        dataReady;
        logic [31:0] data;
    } stage_fwd_t;

endpackage

// File: rtl/operand_forward_mux.sv
// Resolves one source operand against an age-ordered list of in-flight results
// (index 0 youngest), falling back to register-file data.
import decode_operand_stage_pkg::*;

module operand_forward_mux #(
    parameter int XLEN     = 32,
    parameter int REG_ID_W = 5,
    parameter int NUM_SRC  = 4
) (
    input  logic [REG_ID_W-1:0]         read_id,
    input  logic [NUM_SRC*REG_ID_W-1:0] src_id,
    input  logic [NUM_SRC-1:0]          src_ready,
    input  logic [NUM_SRC*XLEN-1:0]     src_data,
    input  logic [XLEN-1:0]             rf_data,
    output logic [XLEN-1:0]             data,
    output logic                        hazard
);

    always_comb begin
        data   = rf_data;
        hazard = 1'b0;
        if (read_id == REG_ID_W'(ZERO_REG)) begin
            data = '0;
        end else begin
            // Walk oldest to youngest so the youngest match is the one left standing.
            for (int i = NUM_SRC - 1; i >= 0; i--) begin
                if (src_id[i*REG_ID_W +: REG_ID_W] == read_id) begin
                    data   = src_data[i*XLEN +: XLEN];
                    hazard = !src_ready[i];
                end
            end
        end
    end

endmodule

// File: rtl/decode_operand_stage.sv
// Decode operand stage: operand forwarding, hazard stall/bubble and output register.
// Optional stall statistics outputs are enabled with DECODE_STALL_STATS_EN.
import decode_operand_stage_pkg::*;

module decode_operand_stage #(
    parameter int XLEN      = 32,
    parameter int REG_ID_W  = 5,
    parameter int NUM_READ  = 2,
    parameter int FWD_DEPTH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         inValid,
    input  logic [XLEN-1:0]              inProgramCounter,
    input  logic [NUM_READ*REG_ID_W-1:0] readId,
    input  logic [NUM_READ-1:0]          readRequired,
    input  logic [NUM_READ*XLEN-1:0]     regFileData,
    input  logic [REG_ID_W-1:0]          writeId,
    input  logic                         writeDataReady,
    input  logic [XLEN-1:0]              writeData,
    input  logic [FWD_DEPTH*REG_ID_W-1:0] fwdId,
    input  logic [FWD_DEPTH-1:0]         fwdReady,
    input  logic [FWD_DEPTH*XLEN-1:0]    fwdData,
    input  logic                         stallIn,
    input  logic                         flush,
    output logic                         stallOut,
    output logic                         outValid,
    output logic [XLEN-1:0]              outProgramCounter,
    output logic [NUM_READ*REG_ID_W-1:0] outReadId,
    output logic [NUM_READ*XLEN-1:0]     outReadData,
    output logic [REG_ID_W-1:0]          outWriteId,
    output logic                         outWriteDataReady,
    output logic [XLEN-1:0]              outWriteData
`ifdef DECODE_STALL_STATS_EN
    ,
    output logic [31:0]                  hazardStallCycles,
    output logic [31:0]                  bubbleCount
`endif
);

    localparam int NUM_SRC = FWD_DEPTH + 1;

    logic [REG_ID_W-1:0]         write_id_q;
    logic                        write_ready_q;
    logic [XLEN-1:0]             write_data_q;
    logic [NUM_READ-1:0]         hazard;
    logic [NUM_READ*XLEN-1:0]    resolved_data;
    logic                        hazard_stall;
    logic [NUM_SRC*REG_ID_W-1:0] src_id;
    logic [NUM_SRC-1:0]          src_ready;
    logic [NUM_SRC*XLEN-1:0]     src_data;

    // A bubble exports id 0 so it can never be matched as a forwarding source.
    assign outWriteId        = outValid ? write_id_q : '0;
    assign outWriteDataReady = !outValid | write_ready_q;
    assign outWriteData      = outValid ? write_data_q : '0;

    assign src_id    = {fwdId, outWriteId};
    assign src_ready = {fwdReady, outWriteDataReady};
    assign src_data  = {fwdData, outWriteData};

    for (genvar p = 0; p < NUM_READ; p++) begin : g_port
        operand_forward_mux #(
            .XLEN     (XLEN),
            .REG_ID_W (REG_ID_W),
            .NUM_SRC  (NUM_SRC)
        ) u_mux (
            .read_id   (readId[p*REG_ID_W +: REG_ID_W]),
            .src_id    (src_id),
            .src_ready (src_ready),
            .src_data  (src_data),
            .rf_data   (regFileData[p*XLEN +: XLEN]),
            .data      (resolved_data[p*XLEN +: XLEN]),
            .hazard    (hazard[p])
        );
    end

    assign hazard_stall = inValid & |(hazard & readRequired);
    assign stallOut     = (hazard_stall | stallIn) & !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outValid          <= 1'b0;
            outProgramCounter <= '0;
            outReadId         <= '0;
            outReadData       <= '0;
            write_id_q        <= '0;
            write_ready_q     <= 1'b1;
            write_data_q      <= '0;
        end else if (flush) begin
            outValid <= 1'b0;
        end else if (stallIn) begin
            // Hold everything, even with a hazard pending, so the held instruction survives.
        end else if (hazard_stall) begin
            outValid <= 1'b0;
        end else begin
            outValid          <= inValid;
            outProgramCounter <= inProgramCounter;
            outReadId         <= readId;
            outReadData       <= resolved_data;
            write_id_q        <= writeId;
            write_ready_q     <= writeDataReady;
            write_data_q      <= writeData;
        end
    end

`ifdef DECODE_STALL_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hazardStallCycles <= '0;
            bubbleCount       <= '0;
        end else begin
            if (hazard_stall && !stallIn && !flush && hazardStallCycles != '1)
                hazardStallCycles <= hazardStallCycles + 32'd1;
            if ((flush || (hazard_stall && !stallIn)) && bubbleCount != '1)
                bubbleCount <= bubbleCount + 32'd1;
        end
    end
`endif

endmodule
